// File: rtl/ysyx_22041461_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one handshaked request at a
// time, drops stale responses after redirects and latches the fetched word for decode.
module ysyx_22041461_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [63:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_data,
    input  logic        ifu_rsp_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  if_err
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] req_addr_q, req_addr_d;
    logic        kill_q, kill_d;
    logic        req_valid_q, req_valid_d;
    logic        rsp_ready_q, rsp_ready_d;
    logic        if_valid_q, if_valid_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [1:0]  if_err_q, if_err_d;
    logic        enter_req_s;
    logic [63:0] next_pc_s;

    // Next-state logic; every path into REQ goes through enter_req_s so the
    // request outputs are prepared one cycle ahead and stay registered.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        req_valid_d = req_valid_q;
        rsp_ready_d = rsp_ready_q;
        if_valid_d  = if_valid_q;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        if_err_d    = if_err_q;
        enter_req_s = 1'b0;
        next_pc_s   = fetch_pc_q;

        case (state_q)
            S_BOOT: begin
                enter_req_s = 1'b1;
                next_pc_s   = redirect_valid ? redirect_pc : fetch_pc_q;
            end
            S_REQ: begin
                if (!req_valid_q) begin
                    // No request was issued: the PC is misaligned.
                    if (redirect_valid) begin
                        enter_req_s = 1'b1;
                        next_pc_s   = redirect_pc;
                    end else begin
                        state_d    = S_HOLD;
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_inst_d  = 32'h0000_0000;
                        if_err_d   = 2'b01;
                    end
                end else begin
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                        kill_d     = 1'b1;
                    end else begin
                        fetch_pc_d = fetch_pc_q;
                    end
                    if (ifu_req_ready) begin
                        req_valid_d = 1'b0;
                        rsp_ready_d = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    if (ifu_rsp_valid) begin
                        // The in-flight response drains right now, so nothing is left to kill.
                        kill_d      = 1'b0;
                        rsp_ready_d = 1'b0;
                        enter_req_s = 1'b1;
                        next_pc_s   = redirect_pc;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (ifu_rsp_valid) begin
                    rsp_ready_d = 1'b0;
                    if (kill_q) begin
                        kill_d      = 1'b0;
                        enter_req_s = 1'b1;
                        next_pc_s   = fetch_pc_q;
                    end else begin
                        state_d    = S_HOLD;
                        if_valid_d = 1'b1;
                        if_pc_d    = req_addr_q;
                        if_inst_d  = ifu_rsp_err ? 32'h0000_0000 : ifu_rsp_data;
                        if_err_d   = ifu_rsp_err ? 2'b10 : 2'b00;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    if_valid_d  = 1'b0;
                    enter_req_s = 1'b1;
                    next_pc_s   = redirect_pc;
                end else if (if_ready) begin
                    if_valid_d  = 1'b0;
                    enter_req_s = 1'b1;
                    next_pc_s   = fetch_pc_q + 64'd4;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (enter_req_s) begin
            state_d     = S_REQ;
            fetch_pc_d  = next_pc_s;
            req_valid_d = (next_pc_s[1:0] == 2'b00);
            req_addr_d  = (next_pc_s[1:0] == 2'b00) ? next_pc_s : req_addr_q;
        end else begin
            req_addr_d = req_addr_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= 64'h0;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= 64'h0;
            if_inst_q   <= 32'h0;
            if_err_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            rsp_ready_q <= rsp_ready_d;
            if_valid_q  <= if_valid_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_err_q    <= if_err_d;
        end
    end

    assign ifu_req_valid = req_valid_q;
    assign ifu_req_addr  = req_addr_q;
    assign ifu_rsp_ready = rsp_ready_q;
    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_inst       = if_inst_q;
    assign if_err        = if_err_q;

endmodule

// File: tb/tb_ysyx_22041461_fetch_unit.sv
// Bench for the fetch unit: a small memory responder plus request/delivery
// scoreboards, a vector table for sequential fetch and hand-written redirect cases.
module tb_ysyx_22041461_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [63:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  if_err;

    ysyx_22041461_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_err(if_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        rsp_err;
        logic [31:0] exp_inst;
        logic [1:0]  exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [1:0]  err;
    } del_t;

    logic [63:0] exp_req[$];
    del_t        exp_del[$];
    vec_t        vecs[6];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cycle = 0;
    int          rsp_delay = 0;
    int          mem_cnt = 0;
    bit          mem_busy = 1'b0;
    logic [63:0] mem_addr = 64'h0;
    logic [63:0] err_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    bit          period_chk = 1'b0;
    bit          have_last = 1'b0;
    int          last_del = 0;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return {a[15:0], 16'h0513};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_del(input logic [63:0] pc, input logic [31:0] inst, input logic [1:0] err);
        del_t d;
        d.pc = pc; d.inst = inst; d.err = err;
        exp_del.push_back(d);
    endtask

    // One clock: scoreboard the handshakes just before the edge, then update the memory model.
    task automatic tick();
        bit          hs_req, hs_rsp, hs_del;
        logic [63:0] rq_addr;
        del_t        d;
        logic [63:0] q;
        @(negedge clk);
        hs_req  = rst && ifu_req_valid && ifu_req_ready;
        hs_rsp  = rst && ifu_rsp_valid && ifu_rsp_ready;
        hs_del  = rst && if_valid && if_ready;
        rq_addr = ifu_req_addr;
        if (hs_req) begin
            if (exp_req.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL req_extra: got request %h expected none", rq_addr);
            end else begin
                q = exp_req.pop_front();
                check("req_addr", rq_addr, q);
            end
        end
        if (hs_del) begin
            if (exp_del.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL del_extra: got pc %h inst %h expected none", if_pc, if_inst);
            end else begin
                d = exp_del.pop_front();
                check("del_pc", if_pc, d.pc);
                check("del_inst", 64'(if_inst), 64'(d.inst));
                check("del_err", 64'(if_err), 64'(d.err));
            end
            if (period_chk && have_last) check("del_period", 64'(cycle - last_del), 64'd3);
            have_last = 1'b1;
            last_del  = cycle;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (!rst) begin
            mem_busy      = 1'b0;
            ifu_rsp_valid = 1'b0;
        end else begin
            if (hs_rsp) begin
                ifu_rsp_valid = 1'b0;
                mem_busy      = 1'b0;
            end
            if (hs_req) begin
                mem_busy = 1'b1;
                mem_cnt  = rsp_delay;
                mem_addr = rq_addr;
            end
            if (mem_busy && !ifu_rsp_valid) begin
                if (mem_cnt == 0) begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_data  = ovr_en ? ovr_data : mem_data(mem_addr);
                    ifu_rsp_err   = (mem_addr == err_addr);
                    ovr_en        = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
        end
    endtask

    task automatic redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic run_until_drained(input int budget);
        for (int k = 0; k < budget && exp_del.size() != 0; k++) tick();
        check("drain_timeout", 64'(exp_del.size()), 64'd0);
        ifu_req_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int k = 0; k < budget && !if_valid; k++) tick();
        check("wait_if_valid", 64'(if_valid), 64'd1);
    endtask

    initial begin
        rst = 1'b0; ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'h0;
        ifu_rsp_err = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; if_ready = 1'b1;
        tick(); tick();
        check("rst_req_valid", 64'(ifu_req_valid), 64'd0);
        check("rst_rsp_ready", 64'(ifu_rsp_ready), 64'd0);
        check("rst_if_valid", 64'(if_valid), 64'd0);
        check("rst_if_pc", if_pc, 64'h0);
        check("rst_if_inst", 64'(if_inst), 64'h0);
        check("rst_if_err", 64'(if_err), 64'h0);
        check("rst_req_addr", ifu_req_addr, 64'h0);

        // Sequential fetch, zero-wait memory, one access fault.
        vecs[0] = '{64'h0000_0000_8000_0000, 1'b0, 32'h0000_0513, 2'b00};
        vecs[1] = '{64'h0000_0000_8000_0004, 1'b0, 32'h0004_0513, 2'b00};
        vecs[2] = '{64'h0000_0000_8000_0008, 1'b0, 32'h0008_0513, 2'b00};
        vecs[3] = '{64'h0000_0000_8000_000C, 1'b0, 32'h000C_0513, 2'b00};
        vecs[4] = '{64'h0000_0000_8000_0010, 1'b1, 32'h0000_0000, 2'b10};
        vecs[5] = '{64'h0000_0000_8000_0014, 1'b0, 32'h0014_0513, 2'b00};
        for (int i = 0; i < 6; i++) begin
            exp_req.push_back(vecs[i].pc);
            push_del(vecs[i].pc, vecs[i].exp_inst, vecs[i].exp_err);
            if (vecs[i].rsp_err) err_addr = vecs[i].pc;
        end
        ifu_req_ready = 1'b1;
        rst = 1'b1;
        tick();
        check("boot_req_valid", 64'(ifu_req_valid), 64'd1);
        check("boot_req_addr", ifu_req_addr, RESET_PC);
        period_chk = 1'b1;
        run_until_drained(40);
        period_chk = 1'b0;

        // Decode backpressure for 5 cycles in HOLD.
        exp_req.push_back(64'h0000_0000_8000_0018);
        if_ready = 1'b0; ifu_req_ready = 1'b1;
        wait_valid(10);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_if_valid", 64'(if_valid), 64'd1);
            check("bp_no_req", 64'(ifu_req_valid), 64'd0);
            check("bp_if_pc", if_pc, 64'h0000_0000_8000_0018);
            check("bp_if_inst", 64'(if_inst), 64'h0018_0513);
        end
        push_del(64'h0000_0000_8000_0018, 32'h0018_0513, 2'b00);
        exp_req.push_back(64'h0000_0000_8000_001C);
        push_del(64'h0000_0000_8000_001C, 32'h001C_0513, 2'b00);
        if_ready = 1'b1;
        run_until_drained(20);

        // Redirect in WAIT; the stale 0xDEADBEEF response arrives two cycles later.
        exp_req.push_back(64'h0000_0000_8000_0020);
        exp_req.push_back(64'h0000_0000_8000_0100);
        push_del(64'h0000_0000_8000_0100, 32'h0100_0513, 2'b00);
        ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        rsp_delay = 2; ifu_req_ready = 1'b1;
        tick();
        redirect(64'h0000_0000_8000_0100);
        rsp_delay = 0;
        run_until_drained(20);

        // Redirect while REQ is stalled, then redirect together with a response in WAIT.
        exp_req.push_back(64'h0000_0000_8000_0104);
        tick();
        check("stall_addr0", ifu_req_addr, 64'h0000_0000_8000_0104);
        redirect(64'h0000_0000_8000_0200);
        check("stall_addr1", ifu_req_addr, 64'h0000_0000_8000_0104);
        tick();
        check("stall_addr2", ifu_req_addr, 64'h0000_0000_8000_0104);
        check("stall_valid", 64'(ifu_req_valid), 64'd1);
        exp_req.push_back(64'h0000_0000_8000_0200);
        exp_req.push_back(64'h0000_0000_8000_0300);
        push_del(64'h0000_0000_8000_0300, 32'h0300_0513, 2'b00);
        ifu_req_ready = 1'b1;
        for (int k = 0; k < 10 && !(mem_busy && ifu_rsp_valid && mem_addr == 64'h0000_0000_8000_0200); k++) tick();
        check("wait_rsp_200", 64'(mem_busy && ifu_rsp_valid && mem_addr == 64'h0000_0000_8000_0200), 64'd1);
        redirect(64'h0000_0000_8000_0300);
        run_until_drained(20);

        // Misaligned redirect from HOLD: no request, error entry delivered.
        exp_req.push_back(64'h0000_0000_8000_0304);
        if_ready = 1'b0; ifu_req_ready = 1'b1;
        wait_valid(10);
        check("hold_pc", if_pc, 64'h0000_0000_8000_0304);
        check("hold_inst", 64'(if_inst), 64'h0304_0513);
        redirect(64'h0000_0000_8000_0102);
        check("mis_no_req0", 64'(ifu_req_valid), 64'd0);
        check("mis_drop_valid", 64'(if_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mis_if_valid", 64'(if_valid), 64'd1);
            check("mis_if_err", 64'(if_err), 64'd1);
            check("mis_if_inst", 64'(if_inst), 64'd0);
            check("mis_if_pc", if_pc, 64'h0000_0000_8000_0102);
            check("mis_no_req", 64'(ifu_req_valid), 64'd0);
        end

        // Redirect and consume in the same HOLD cycle; target faults.
        push_del(64'h0000_0000_8000_0102, 32'h0000_0000, 2'b01);
        exp_req.push_back(64'h0000_0000_8000_0010);
        if_ready = 1'b1;
        redirect(64'h0000_0000_8000_0010);
        if_ready = 1'b0;
        wait_valid(10);
        check("fault_pc", if_pc, 64'h0000_0000_8000_0010);
        check("fault_err", 64'(if_err), 64'd2);
        check("fault_inst", 64'(if_inst), 64'd0);
        check("fault_drained", 64'(exp_del.size()), 64'd0);

        // Reset asserted in HOLD.
        rst = 1'b0;
        tick();
        check("mid_rst_if_valid", 64'(if_valid), 64'd0);
        check("mid_rst_req_valid", 64'(ifu_req_valid), 64'd0);
        check("mid_rst_if_pc", if_pc, 64'h0);
        check("mid_rst_if_err", 64'(if_err), 64'd0);
        exp_req.push_back(RESET_PC);
        push_del(RESET_PC, 32'h0000_0513, 2'b00);
        rst = 1'b1;
        if_ready = 1'b1;
        tick();
        check("rerst_req_valid", 64'(ifu_req_valid), 64'd1);
        check("rerst_req_addr", ifu_req_addr, RESET_PC);
        run_until_drained(20);
        check("req_queue_empty", 64'(exp_req.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_fetch_unit.md
# ysyx_22041461_fetch_unit

Instruction fetch stage for the ysyx_22041461 RV64 core. It replaces the combinational instruction read with a handshaked fetch. It owns the fetch PC, issues one 32-bit instruction request at a time to the instruction memory port, and holds the returned instruction with its PC for the decode/control stage. It accepts redirects (branch, jump, mret, trap vector) from the PC-select logic and discards stale responses. It flags misaligned fetches and access faults.

## Interface

- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- ifu_req_valid  output  1  instruction request valid
- ifu_req_ready  input  1  memory accepts request
- ifu_req_addr  output  64  request address, 4-byte aligned
- ifu_rsp_valid  input  1  memory response valid
- ifu_rsp_ready  output  1  fetch unit accepts response
- ifu_rsp_data  input  32  instruction word
- ifu_rsp_err  input  1  access fault for this response
- redirect_valid  input  1  next fetch PC override, single-cycle pulse
- redirect_pc  input  64  redirect target
- if_valid  output  1  held instruction valid to decode
- if_ready  input  1  decode consumes instruction
- if_pc  output  64  PC of held instruction
- if_inst  output  32  held instruction; 32'h0 when if_err != 0
- if_err  output  2  00 none, 01 misaligned fetch, 10 access fault

## Operation

- Registers:
  - fetch_pc: next PC to fetch.
  - req_addr: frozen address of the in-flight request.
  - kill: the in-flight response is stale.
  - Output latch: if_pc, if_inst, if_err.
- States are BOOT, REQ, WAIT and HOLD.
- BOOT:
  - Entered on reset. All handshake outputs are 0.
  - Next cycle goes to REQ.
- REQ:
  - If fetch_pc[1:0] != 0: issue no request. Latch if_pc=fetch_pc, if_err=01, if_inst=0. Go to HOLD.
  - Otherwise: ifu_req_valid=1, ifu_req_addr=req_addr=fetch_pc.
  - ifu_req_valid and ifu_req_addr stay stable until ifu_req_ready. On the handshake, go to WAIT.
- WAIT:
  - ifu_rsp_ready=1.
  - On ifu_rsp_valid with kill=0: latch if_pc=req_addr, if_inst=data (or 0 if err), if_err=err?10:00. Go to HOLD.
  - On ifu_rsp_valid with kill=1: discard the response, clear kill, go to REQ.
- HOLD:
  - if_valid=1.
  - On if_ready: fetch_pc <= fetch_pc+4 (wraps mod 2^64). Go to REQ.
- Redirect (priority over sequential update):
  - BOOT: fetch_pc <= redirect_pc.
  - REQ, no handshake this cycle:
    - fetch_pc <= redirect_pc.
    - The current request stays asserted unchanged.
    - kill <= 1 at acceptance.
  - REQ with handshake this cycle: fetch_pc <= redirect_pc, kill <= 1, go to WAIT.
  - WAIT: fetch_pc <= redirect_pc, kill <= 1. A response in the same cycle is discarded and the next state is REQ.
  - HOLD:
    - if_valid drops next cycle and the state goes to REQ with fetch_pc=redirect_pc.
    - If if_ready was also high, the handshake completes (instruction delivered) and redirect_pc still wins over +4.
  - Misaligned REQ (no request issued): redirect wins, fetch_pc <= redirect_pc, stay in REQ.
- Only one request is outstanding at a time. ifu_rsp_valid outside WAIT is not accepted (ifu_rsp_ready=0).
- if_pc, if_inst and if_err are stable while if_valid=1 and if_ready=0.
- Faulted and misaligned entries are delivered like normal instructions. The trap logic redirects.

## Timing

- Reset (rst=0 at an edge):
  - State goes to BOOT; fetch_pc=RESET_PC, kill=0.
  - ifu_req_valid=0, ifu_rsp_ready=0, if_valid=0.
  - if_pc=0, if_inst=0, if_err=0, ifu_req_addr=0.
- Reset mid-operation aborts everything. A response arriving during or after reset for a pre-reset request is ignored until the next WAIT.
  - A post-reset WAIT may still see a pre-reset response; the memory side is also reset and owns this.
- Path from the first edge with rst=1:
  - BOOT, then REQ with ifu_req_valid=1 and addr RESET_PC.
- Zero-wait memory (ready in REQ, rsp one cycle after accept):
  - REQ: 1 cycle.
  - WAIT: 1 cycle.
  - if_valid on cycle 3 from REQ entry.
  - Throughput is one instruction per 3 cycles.
- Misaligned fetch: if_valid one cycle after REQ entry.
- Redirect to first request at the new PC:
  - 1 cycle from HOLD or REQ without an in-flight request.
  - Otherwise after the stale response drains, plus 1.
- All outputs are driven from registers or state decode; there are no combinational input-to-output paths.

## Test plan

- Reset, then memory always ready with a 1-cycle response:
  - ifu_req_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
  - if_valid every 3rd cycle with matching if_pc/if_inst.
- Decode backpressure:
  - Hold if_ready=0 for 5 cycles in HOLD.
  - if_pc/if_inst stay constant and no new request is issued. Release: next req addr is +4.
- Redirect in WAIT to 0x8000_0100, response 0xDEADBEEF arriving 2 cycles later:
  - The response is discarded (never if_valid).
  - Next request addr is 0x8000_0100.
- Redirect and response in the same WAIT cycle, plus redirect while REQ is stalled (ifu_req_ready=0 for 3 cycles):
  - The stalled address is held constant.
  - Both stale responses are dropped.
  - Fetch resumes at redirect_pc.
- redirect_pc=0x8000_0102:
  - No request is issued.
  - if_valid with if_err=01, if_inst=0, if_pc=0x8000_0102.
- ifu_rsp_err=1 at 0x8000_0010:
  - if_err=10, if_inst=0.
  - Separately, rst=0 asserted in HOLD: the next cycle has if_valid=0 and the first request after release is at RESET_PC.
